// File: rtl/complete_arbiter_pkg.sv
// Shared completion-packet types, lane count and arbiter helpers.
// Exports sys_defs (FU_COMPLETE_PACKET) and complete_arbiter_pkg.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package sys_defs;

  localparam int SUPERSCALAR_WAYS_P = `SUPERSCALAR_WAYS;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pr_idx;
    logic [4:0]  rob_idx;
    logic [31:0] dest_value;
    logic        take_branch;
    logic [31:0] target_pc;
    logic        wr_mem;
    logic [31:0] opb;
  } FU_COMPLETE_PACKET;

endpackage

package complete_arbiter_pkg;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-to-complete-stage bundle: squash, per-FU results/ready, lanes.
// master drives results and squash; slave is the arbiter.
interface complete_arbiter_if
  import sys_defs::*;
#(
  parameter int NUM_FU = 6,
  parameter int WAYS   = `SUPERSCALAR_WAYS
);

  logic                            squash;
  FU_COMPLETE_PACKET [NUM_FU-1:0]  fu_result_in;
  logic [NUM_FU-1:0]               fu_ready_out;
  FU_COMPLETE_PACKET [WAYS-1:0]    complete_fu_out;

  modport master (
    output squash,
    output fu_result_in,
    input  fu_ready_out,
    input  complete_fu_out
  );

  modport slave (
    input  squash,
    input  fu_result_in,
    output fu_ready_out,
    output complete_fu_out
  );

endinterface

// File: rtl/complete_arbiter_rr_multi_select.sv
// Picks up to W requesters scanning from ptr, modulo N.
// Ports: req, ptr in; grant, sel_valid/sel_idx (scan order), next_ptr out.
module rr_multi_select #(
  parameter int N  = 6,
  parameter int W  = 3,
  parameter int PW = 3
) (
  input  logic [N-1:0]          req,
  input  logic [PW-1:0]         ptr,
  output logic [N-1:0]          grant,
  output logic [W-1:0]          sel_valid,
  output logic [W-1:0][PW-1:0]  sel_idx,
  output logic [PW-1:0]         next_ptr
);

  logic [PW:0]   jsum;
  logic [PW-1:0] j;
  int            cnt;

  always_comb begin
    grant     = '0;
    sel_valid = '0;
    sel_idx   = '0;
    next_ptr  = ptr;
    jsum      = '0;
    j         = '0;
    cnt       = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      jsum = {1'b0, ptr} + (PW+1)'(k);
      if (jsum >= (PW+1)'(N))
        jsum = jsum - (PW+1)'(N);
      j = jsum[PW-1:0];
      if (req[j] && cnt < W) begin
        for (int i = 0; i < N; i++)
          if (j == PW'(i))
            grant[i] = 1'b1;
        for (int l = 0; l < W; l++) begin
          if (cnt == l) begin
            sel_valid[l] = 1'b1;
            sel_idx[l]   = j;
          end
        end
        if (j == PW'(N - 1))
          next_ptr = '0;
        else
          next_ptr = j + PW'(1);
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Holds one result per FU and drains up to WAYS per cycle, round-robin.
// Ports: clock, reset_n, bus (slave: squash, fu_result_in/ready, lanes).
module complete_arbiter
  import sys_defs::*;
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = 6,
  parameter int WAYS   = `SUPERSCALAR_WAYS
) (
  input  logic               clock,
  input  logic               reset_n,
  complete_arbiter_if.slave  bus
);

  localparam int PW = ptr_w(NUM_FU);

  logic [NUM_FU-1:0]              hold_valid;
  FU_COMPLETE_PACKET [NUM_FU-1:0] hold_pkt;
  logic [PW-1:0]                  rr_ptr;
  FU_COMPLETE_PACKET [WAYS-1:0]   lane_q;

  logic [NUM_FU-1:0]              grant;
  logic [NUM_FU-1:0]              fu_ready;
  logic [NUM_FU-1:0]              accept;
  logic [WAYS-1:0]                sel_valid;
  logic [WAYS-1:0][PW-1:0]        sel_idx;
  logic [PW-1:0]                  next_ptr;
  FU_COMPLETE_PACKET [WAYS-1:0]   lane_d;

  rr_multi_select #(
    .N  (NUM_FU),
    .W  (WAYS),
    .PW (PW)
  ) u_sel (
    .req       (hold_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .next_ptr  (next_ptr)
  );

  // A slot being drained this cycle can take a new result at once.
  assign fu_ready = {NUM_FU{bus.squash}} | ~hold_valid | grant;
  assign bus.fu_ready_out = fu_ready;
  assign bus.complete_fu_out = lane_q;

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_FU; i++)
      accept[i] = bus.fu_result_in[i].valid & fu_ready[i];
  end

  always_comb begin
    lane_d = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (sel_valid[k]) begin
        lane_d[k]       = hold_pkt[sel_idx[k]];
        lane_d[k].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= '0;
      hold_pkt   <= '0;
      rr_ptr     <= '0;
      lane_q     <= '0;
    end else if (bus.squash) begin
      hold_valid <= '0;
      lane_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          hold_pkt[i]   <= bus.fu_result_in[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      lane_q <= lane_d;
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: latency, ordering, squash, reset.
// Drives at posedge+1, samples at negedge.
module tb_complete_arbiter;
  import sys_defs::*;

  localparam int NF = 6;
  localparam int NW = SUPERSCALAR_WAYS_P;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  complete_arbiter_if #(.NUM_FU(NF), .WAYS(NW)) bus ();

  complete_arbiter #(.NUM_FU(NF), .WAYS(NW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic FU_COMPLETE_PACKET mk(input int fu, input int rob);
    FU_COMPLETE_PACKET p;
    int r;
    r = rob % 32;
    p = '0;
    p.valid       = 1'b1;
    p.pr_idx      = 6'(fu);
    p.rob_idx     = 5'(r);
    p.dest_value  = 32'hA000_0000 + 32'(fu * 256 + r);
    p.take_branch = r[0];
    p.target_pc   = 32'h1000_0000 + 32'(r * 4);
    p.wr_mem      = fu[0];
    p.opb         = ~p.dest_value ^ 32'(fu);
    return p;
  endfunction

  int seq [NF];
  int expn [NF];
  int accepted;
  int emitted;

  task automatic observe(input bit pattern, input int base);
    FU_COMPLETE_PACKET l;
    int f;
    for (int k = 0; k < NW; k++) begin
      l = bus.complete_fu_out[k];
      if (pattern) begin
        check("full_lane_valid", l.valid, 1);
        check("full_lane_fu", l.pr_idx, base + k);
      end
      if (l.valid) begin
        f = int'(l.pr_idx);
        if (f < NF) begin
          check("full_lane_pkt", l, mk(f, expn[f]));
          expn[f]++;
        end else begin
          check("full_lane_range", f, 0);
        end
        emitted++;
      end
    end
  endtask

  initial begin
    FU_COMPLETE_PACKET zp;
    logic [NF-1:0] exp_ready;
    checks   = 0;
    errors   = 0;
    accepted = 0;
    emitted  = 0;
    zp = '0;
    rst_n = 1'b0;
    bus.squash = 1'b0;
    bus.fu_result_in = '0;

    #2;
    check("rst_out", bus.complete_fu_out, '0);
    check("rst_ready", bus.fu_ready_out, 6'h3F);
    check("rst_rr", dut.rr_ptr, 0);
    #10 rst_n = 1'b1;

    // single FU2 result: two-cycle latency, lane 0 only
    next_cycle();
    bus.fu_result_in[2] = mk(2, 5);
    @(negedge clk);
    check("single_ready", bus.fu_ready_out, 6'h3F);
    next_cycle();
    bus.fu_result_in = '0;
    @(negedge clk);
    check("single_t1_zero", bus.complete_fu_out, '0);
    next_cycle();
    @(negedge clk);
    check("single_lane0", bus.complete_fu_out[0], mk(2, 5));
    check("single_lane1", bus.complete_fu_out[1], zp);
    check("single_lane2", bus.complete_fu_out[2], zp);
    check("single_rr", dut.rr_ptr, 3);
    next_cycle();
    @(negedge clk);
    check("single_zeroed", bus.complete_fu_out, '0);

    // FU0 + FU4 from rr_ptr=3: FU4 first, pointer to 1
    next_cycle();
    bus.fu_result_in[0] = mk(0, 11);
    bus.fu_result_in[4] = mk(4, 12);
    next_cycle();
    bus.fu_result_in = '0;
    @(negedge clk);
    check("wrap_ready", bus.fu_ready_out, 6'h3F);
    next_cycle();
    @(negedge clk);
    check("wrap_lane0", bus.complete_fu_out[0], mk(4, 12));
    check("wrap_lane1", bus.complete_fu_out[1], mk(0, 11));
    check("wrap_lane2", bus.complete_fu_out[2], zp);
    check("wrap_rr", dut.rr_ptr, 1);

    // FU1 granted and reloaded in the same cycle, no bubble
    next_cycle();
    bus.fu_result_in[1] = mk(1, 7);
    next_cycle();
    bus.fu_result_in[1] = mk(1, 9);
    @(negedge clk);
    check("reload_ready", bus.fu_ready_out[1], 1);
    next_cycle();
    bus.fu_result_in = '0;
    @(negedge clk);
    check("reload_first", bus.complete_fu_out[0], mk(1, 7));
    check("reload_first_l1", bus.complete_fu_out[1], zp);
    next_cycle();
    @(negedge clk);
    check("reload_second", bus.complete_fu_out[0], mk(1, 9));
    check("reload_rr", dut.rr_ptr, 2);

    // squash with holds 0-2 full and FU3 presenting
    next_cycle();
    bus.fu_result_in[0] = mk(0, 20);
    bus.fu_result_in[1] = mk(1, 21);
    bus.fu_result_in[2] = mk(2, 22);
    next_cycle();
    bus.fu_result_in = '0;
    bus.squash = 1'b1;
    bus.fu_result_in[3] = mk(3, 25);
    @(negedge clk);
    check("squash_ready", bus.fu_ready_out, 6'h3F);
    next_cycle();
    bus.squash = 1'b0;
    bus.fu_result_in = '0;
    @(negedge clk);
    check("squash_out", bus.complete_fu_out, '0);
    check("squash_rr", dut.rr_ptr, 2);
    check("squash_empty", bus.fu_ready_out, 6'h3F);
    next_cycle();
    @(negedge clk);
    check("squash_dropped", bus.complete_fu_out, '0);

    // asynchronous reset in the middle of a burst
    next_cycle();
    for (int i = 0; i < NF; i++)
      bus.fu_result_in[i] = mk(i, i + 1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("arst_pre", bus.complete_fu_out[0].valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", bus.complete_fu_out, '0);
    check("arst_ready", bus.fu_ready_out, 6'h3F);
    check("arst_rr", dut.rr_ptr, 0);
    bus.fu_result_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    check("arst_no_old", bus.complete_fu_out, '0);
    bus.fu_result_in[5] = mk(5, 17);
    next_cycle();
    bus.fu_result_in = '0;
    @(negedge clk);
    check("arst_t1", bus.complete_fu_out, '0);
    next_cycle();
    @(negedge clk);
    check("arst_lane0", bus.complete_fu_out[0], mk(5, 17));
    check("arst_lane1", bus.complete_fu_out[1], zp);
    check("arst_rr", dut.rr_ptr, 0);
    next_cycle();
    @(negedge clk);
    check("arst_idle", bus.complete_fu_out, '0);
    next_cycle();

    // all six FUs valid every cycle for 100 cycles
    for (int i = 0; i < NF; i++) begin
      seq[i]  = 0;
      expn[i] = 0;
    end
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < NF; i++)
        bus.fu_result_in[i] = mk(i, seq[i]);
      @(negedge clk);
      if (n == 0)
        exp_ready = 6'h3F;
      else if (n % 2 == 1)
        exp_ready = 6'h07;
      else
        exp_ready = 6'h38;
      check("full_ready", bus.fu_ready_out, exp_ready);
      if (n < 2)
        check("full_lane_idle", bus.complete_fu_out, '0);
      else
        observe(1'b1, (n % 2 == 0) ? 0 : 3);
      for (int i = 0; i < NF; i++) begin
        if (bus.fu_ready_out[i]) begin
          seq[i]++;
          accepted++;
        end
      end
      next_cycle();
    end
    bus.fu_result_in = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      observe(1'b0, 0);
      next_cycle();
    end
    check("full_no_loss", emitted, accepted);
    check("full_drained", bus.complete_fu_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
